// File: rtl/arf156b040e2r2w0cbbehbaa4acw_gclk_rpen_ctrl.sv
// Regional power-enable controller for the RCB clock-gate stage.
// Filters array activity requests through a wake delay and a hysteresis window,
// producing RPEn for the RCB, RcbRdy once the gated clock has settled, and a
// saturating telemetry count of cycles spent gated (IDLE).
//
// Ports:
//   CkGridX1N    in   ungated grid clock, all state on its rising edge
//   Rst          in   synchronous reset, active-high
//   ActReq       in   activity request level (any rd/wr port pending)
//   CfgHystCnt   in   cycles RPEn stays high after ActReq drops
//   CfgWakeDly   in   cycles from RPEn rise to RcbRdy rise
//   GatedCycClr  in   synchronous clear of GatedCyc
//   RPEn         out  regional power enable (1 = clock runs)
//   RcbRdy       out  RCB clock enabled and settled
//   CtlState     out  FSM state: 0 IDLE, 1 WAKE, 2 ACTIVE, 3 HYST
//   GatedCyc     out  saturating count of cycles spent in IDLE
module arf156b040e2r2w0cbbehbaa4acw_gclk_rpen_ctrl #(
    parameter int unsigned HYST_W = 4,
    parameter int unsigned WAKE_W = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CkGridX1N,
    input  logic              Rst,
    input  logic              ActReq,
    input  logic [HYST_W-1:0] CfgHystCnt,
    input  logic [WAKE_W-1:0] CfgWakeDly,
    input  logic              GatedCycClr,
    output logic              RPEn,
    output logic              RcbRdy,
    output logic [1:0]        CtlState,
    output logic [CNT_W-1:0]  GatedCyc
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWake   = 2'd1,
        StActive = 2'd2,
        StHyst   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WAKE_W-1:0]  wk_cnt_q, wk_cnt_d;
    logic [HYST_W-1:0]  hy_cnt_q, hy_cnt_d;
    logic [CNT_W-1:0]   gated_q, gated_d;
    logic               rpen_q, rcb_rdy_q;

    localparam logic [CNT_W-1:0] GatedMax = {CNT_W{1'b1}};

    always_comb begin
        state_d  = state_q;
        wk_cnt_d = wk_cnt_q;
        hy_cnt_d = hy_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (ActReq) begin
                    if (CfgWakeDly != '0) begin
                        state_d  = StWake;
                        wk_cnt_d = CfgWakeDly;
                    end else begin
                        state_d = StActive;
                    end
                end
            end
            StWake: begin
                // ActReq deliberately ignored: a started wake always completes.
                wk_cnt_d = wk_cnt_q - 1'b1;
                if (wk_cnt_q == WAKE_W'(1)) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                if (!ActReq) begin
                    if (CfgHystCnt != '0) begin
                        state_d  = StHyst;
                        hy_cnt_d = CfgHystCnt;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StHyst: begin
                if (ActReq) begin
                    state_d = StActive;
                end else begin
                    hy_cnt_d = hy_cnt_q - 1'b1;
                    if (hy_cnt_q == HYST_W'(1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Counts edges at which the registered state is IDLE; clear beats increment.
    always_comb begin
        gated_d = gated_q;
        if (GatedCycClr) begin
            gated_d = '0;
        end else if (state_q == StIdle && gated_q != GatedMax) begin
            gated_d = gated_q + 1'b1;
        end
    end

    always_ff @(posedge CkGridX1N) begin
        if (Rst) begin
            state_q   <= StIdle;
            wk_cnt_q  <= '0;
            hy_cnt_q  <= '0;
            gated_q   <= '0;
            rpen_q    <= 1'b0;
            rcb_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wk_cnt_q  <= wk_cnt_d;
            hy_cnt_q  <= hy_cnt_d;
            gated_q   <= gated_d;
            // Outputs decoded from next state so they are flop-driven and glitch-free.
            rpen_q    <= (state_d != StIdle);
            rcb_rdy_q <= (state_d == StActive) || (state_d == StHyst);
        end
    end

    assign RPEn     = rpen_q;
    assign RcbRdy   = rcb_rdy_q;
    assign CtlState = state_q;
    assign GatedCyc = gated_q;

endmodule

// File: tb/tb_arf156b040e2r2w0cbbehbaa4acw_gclk_rpen_ctrl.sv
// Directed bench for the regional power-enable controller (CNT_W=4).
module tb_arf156b040e2r2w0cbbehbaa4acw_gclk_rpen_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       act_req;
    logic [3:0] cfg_hyst;
    logic [1:0] cfg_wake;
    logic       gated_clr;
    logic       rpen;
    logic       rcb_rdy;
    logic [1:0] ctl_state;
    logic [3:0] gated_cyc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arf156b040e2r2w0cbbehbaa4acw_gclk_rpen_ctrl #(
        .HYST_W(4),
        .WAKE_W(2),
        .CNT_W (4)
    ) dut (
        .CkGridX1N  (clk),
        .Rst        (rst),
        .ActReq     (act_req),
        .CfgHystCnt (cfg_hyst),
        .CfgWakeDly (cfg_wake),
        .GatedCycClr(gated_clr),
        .RPEn       (rpen),
        .RcbRdy     (rcb_rdy),
        .CtlState   (ctl_state),
        .GatedCyc   (gated_cyc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks RPEn, RcbRdy and CtlState together.
    task automatic chk_st(input string tag, input logic pe, input logic rdy, input logic [1:0] st);
        chk({tag, ".rpen"}, 32'(rpen), 32'(pe));
        chk({tag, ".rdy"}, 32'(rcb_rdy), 32'(rdy));
        chk({tag, ".state"}, 32'(ctl_state), 32'(st));
    endtask

    initial begin
        rst       = 1'b1;
        act_req   = 1'b1;
        cfg_wake  = 2'd2;
        cfg_hyst  = 4'd5;
        gated_clr = 1'b0;

        // Reset held two cycles with ActReq high
        step();
        chk_st("rst0", 1'b0, 1'b0, 2'd0);
        chk("rst0.gated", 32'(gated_cyc), 32'd0);
        step();
        chk_st("rst1", 1'b0, 1'b0, 2'd0);
        chk("rst1.gated", 32'(gated_cyc), 32'd0);

        rst     = 1'b0;
        act_req = 1'b0;
        step();
        chk_st("idle", 1'b0, 1'b0, 2'd0);
        chk("idle.gated", 32'(gated_cyc), 32'd1);

        // Wake with CfgWakeDly=2
        act_req = 1'b1;
        step();
        chk_st("wake.e1", 1'b1, 1'b0, 2'd1);
        chk("wake.gated", 32'(gated_cyc), 32'd2);
        step();
        chk_st("wake.e2", 1'b1, 1'b0, 2'd1);
        step();
        chk_st("wake.e3", 1'b1, 1'b1, 2'd2);
        chk("wake.gated_hold", 32'(gated_cyc), 32'd2);

        // Hysteresis of 5 cycles
        act_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_st("hyst.run", 1'b1, 1'b1, 2'd3);
        end
        step();
        chk_st("hyst.end", 1'b0, 1'b0, 2'd0);
        chk("hyst.gated", 32'(gated_cyc), 32'd2);

        // Re-wake; changing CfgWakeDly mid-count must not stretch it
        act_req = 1'b1;
        step();
        chk_st("rewake.e1", 1'b1, 1'b0, 2'd1);
        chk("rewake.gated", 32'(gated_cyc), 32'd3);
        cfg_wake = 2'd3;
        step();
        chk_st("rewake.e2", 1'b1, 1'b0, 2'd1);
        step();
        chk_st("rewake.e3", 1'b1, 1'b1, 2'd2);

        // Hysteresis cut short at HYST cycle 3
        act_req = 1'b0;
        step();
        chk_st("hcut.h1", 1'b1, 1'b1, 2'd3);
        step();
        chk_st("hcut.h2", 1'b1, 1'b1, 2'd3);
        step();
        chk_st("hcut.h3", 1'b1, 1'b1, 2'd3);
        act_req = 1'b1;
        step();
        chk_st("hcut.back", 1'b1, 1'b1, 2'd2);
        step();
        chk_st("hcut.stay", 1'b1, 1'b1, 2'd2);

        // Zero config: one-cycle pulse gives IDLE->ACTIVE->IDLE
        cfg_wake = 2'd0;
        cfg_hyst = 4'd0;
        act_req  = 1'b0;
        step();
        chk_st("zero.drop", 1'b0, 1'b0, 2'd0);
        act_req = 1'b1;
        step();
        chk_st("zero.act", 1'b1, 1'b1, 2'd2);
        act_req = 1'b0;
        step();
        chk_st("zero.idle", 1'b0, 1'b0, 2'd0);
        step();
        chk_st("zero.idle2", 1'b0, 1'b0, 2'd0);

        // Saturation and clear of GatedCyc
        for (int i = 0; i < 20; i++) begin
            step();
        end
        chk("gated.sat", 32'(gated_cyc), 32'd15);
        step();
        chk("gated.sat_hold", 32'(gated_cyc), 32'd15);
        gated_clr = 1'b1;
        step();
        chk("gated.clr", 32'(gated_cyc), 32'd0);
        gated_clr = 1'b0;
        step();
        chk("gated.resume1", 32'(gated_cyc), 32'd1);
        step();
        chk("gated.resume2", 32'(gated_cyc), 32'd2);

        // Reset in WAKE with WkCnt=1
        cfg_wake = 2'd2;
        act_req  = 1'b1;
        step();
        step();
        chk_st("rw.pre", 1'b1, 1'b0, 2'd1);
        rst = 1'b1;
        step();
        chk_st("rw.rst", 1'b0, 1'b0, 2'd0);
        chk("rw.gated", 32'(gated_cyc), 32'd0);
        rst      = 1'b0;
        cfg_wake = 2'd3;
        step();
        chk_st("rw.load", 1'b1, 1'b0, 2'd1);
        chk("rw.gated1", 32'(gated_cyc), 32'd1);
        step();
        chk_st("rw.w2", 1'b1, 1'b0, 2'd1);
        step();
        chk_st("rw.w3", 1'b1, 1'b0, 2'd1);
        step();
        chk_st("rw.act", 1'b1, 1'b1, 2'd2);

        // Reset in HYST with HyCnt=3
        cfg_hyst = 4'd5;
        act_req  = 1'b0;
        step();
        step();
        step();
        chk_st("rh.pre", 1'b1, 1'b1, 2'd3);
        rst = 1'b1;
        step();
        chk_st("rh.rst", 1'b0, 1'b0, 2'd0);
        rst      = 1'b0;
        cfg_wake = 2'd0;
        cfg_hyst = 4'd2;
        act_req  = 1'b1;
        step();
        chk_st("rh.act", 1'b1, 1'b1, 2'd2);
        act_req = 1'b0;
        step();
        chk_st("rh.h1", 1'b1, 1'b1, 2'd3);
        step();
        chk_st("rh.h2", 1'b1, 1'b1, 2'd3);
        step();
        chk_st("rh.idle", 1'b0, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
